// File: rtl/ising_csr_pkg.sv
// Shared address map, response codes and run-state encoding for the Ising CSR responder.
package ising_csr_pkg;

  localparam int unsigned ADDR_STRIDE = 32;
  localparam int unsigned STRIDE_LSB  = $clog2(ADDR_STRIDE);

  localparam logic [31:0] START_ADDR       = 32'h0000_0000;
  localparam logic [31:0] CTR_CUTOFF_ADDR  = 32'h0000_0020;
  localparam logic [31:0] CTR_MAX_ADDR     = 32'h0000_0040;
  localparam logic [31:0] STATUS_ADDR      = 32'h0000_0060;
  localparam logic [31:0] PHASE_ADDR_BASE  = 32'h0001_0000;
  localparam logic [31:0] WEIGHT_ADDR_BASE = 32'h0002_0000;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } run_state_e;

  // Array regions are 64 KiB windows; entries sit on stride boundaries only.
  function automatic logic in_region(input logic [31:0] addr, input logic [31:0] base);
    return (addr[31:16] == base[31:16]) && (addr[STRIDE_LSB-1:0] == '0);
  endfunction

  function automatic logic [10:0] entry_idx(input logic [31:0] addr);
    return 11'(addr[15:0] >> STRIDE_LSB);
  endfunction

endpackage

// File: rtl/ising_run_ctrl.sv
// Anneal-window FSM: IDLE/RUN/DONE, 32-bit run counter, cutoff compare, phase latch at counter==ctr_max.
// Outputs are decoded from registered state (zero added latency); START always wins over the final match.
module ising_run_ctrl
  import ising_csr_pkg::*;
#(
  parameter int N = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start_vld,
  input  logic          i_start_go,
  input  logic [31:0]   i_ctr_cutoff,
  input  logic [31:0]   i_ctr_max,
  input  logic [N-1:0]  i_phase,
  output logic          o_run,
  output logic          o_sample_en,
  output logic          o_done,
  output logic [N-1:0]  o_phase_q
);

  run_state_e r_state;
  run_state_e w_state_nxt;
  logic [31:0]  r_ctr;
  logic [N-1:0] r_phase_q;
  logic         w_final;

  assign w_final = (r_state == RUN) && (r_ctr == i_ctr_max) && !i_start_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (i_start_vld && i_start_go) w_state_nxt = RUN;
      RUN: begin
        if (i_start_vld) begin
          w_state_nxt = i_start_go ? RUN : IDLE;
        end else if (r_ctr == i_ctr_max) begin
          w_state_nxt = DONE;
        end
      end
      DONE: if (i_start_vld && i_start_go) w_state_nxt = RUN;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctr     <= '0;
      r_phase_q <= '0;
    end else begin
      if (i_start_vld && i_start_go) begin
        r_ctr <= '0;
      end else if ((r_state == RUN) && !i_start_vld && (r_ctr != i_ctr_max)) begin
        r_ctr <= r_ctr + 32'd1;
      end
      if (w_final) begin
        r_phase_q <= i_phase;
      end
    end
  end

  always_comb begin
    o_run       = 1'b0;
    o_sample_en = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      RUN: begin
        o_run       = 1'b1;
        o_sample_en = (r_ctr >= i_ctr_cutoff);
      end
      DONE:    o_done = 1'b1;
      default: ;
    endcase
  end

  assign o_phase_q = r_phase_q;

endmodule

// File: rtl/ising_csr_resp.sv
// Ising register-file responder: address decode, weight registers, 1-cycle registered read mux, no read backpressure.
// Optional ISING_RESP_WEIGHT_RDBACK_EN builds the weight readback mux; otherwise weight reads return 0/OKAY.
module ising_csr_resp
  import ising_csr_pkg::*;
#(
  parameter int N           = 6,
  parameter int NUM_WEIGHTS = 3,
  parameter logic [NUM_WEIGHTS-1:0] WEIGHT_RST = '0,
  localparam int NUM_PAIRS  = N * (N - 1) / 2
) (
  input  logic                             clk,
  input  logic                             axi_rstn,
  input  logic                             wr_valid,
  input  logic [31:0]                      wr_addr,
  input  logic [31:0]                      wdata,
  input  logic                             arvalid_q,
  input  logic [31:0]                      araddr_q,
  input  logic                             rready,
  output logic                             rvalid,
  output logic [1:0]                       rresp,
  output logic [31:0]                      rdata,
  output logic [NUM_PAIRS*NUM_WEIGHTS-1:0] weights_o,
  output logic                             run_o,
  output logic                             sample_en_o,
  input  logic [N-1:0]                     phase_i
);

  localparam logic [10:0] NUM_PAIRS_L = 11'(NUM_PAIRS);
  localparam logic [10:0] N_L         = 11'(N);

  logic [NUM_PAIRS*NUM_WEIGHTS-1:0] r_weights;
  logic [31:0] r_ctr_cutoff;
  logic [31:0] r_ctr_max;
  logic        r_rvalid;
  logic [1:0]  r_rresp;
  logic [31:0] r_rdata;

  logic        w_run;
  logic        w_done;
  logic [N-1:0] w_phase_q;
  logic        w_wr_start;
  logic        w_wr_cut;
  logic        w_wr_max;
  logic        w_wr_wt;
  logic [10:0] w_wr_idx;
  logic [10:0] w_rd_idx;
  logic [31:0] w_rd_dat;
  logic [1:0]  w_rd_resp;
  logic        w_unused;

  // rready is reserved: reads are never stalled.
  assign w_unused = rready;

  assign w_wr_idx   = entry_idx(wr_addr);
  assign w_rd_idx   = entry_idx(araddr_q);
  assign w_wr_start = wr_valid && (wr_addr == START_ADDR);
  assign w_wr_cut   = wr_valid && (wr_addr == CTR_CUTOFF_ADDR) && !w_run;
  assign w_wr_max   = wr_valid && (wr_addr == CTR_MAX_ADDR) && !w_run;
  assign w_wr_wt    = wr_valid && in_region(wr_addr, WEIGHT_ADDR_BASE) &&
                      (w_wr_idx < NUM_PAIRS_L) && !w_run;

  ising_run_ctrl #(.N(N)) u_run_ctrl (
    .clk          (clk),
    .rst_n        (axi_rstn),
    .i_start_vld  (w_wr_start),
    .i_start_go   (wdata[0]),
    .i_ctr_cutoff (r_ctr_cutoff),
    .i_ctr_max    (r_ctr_max),
    .i_phase      (phase_i),
    .o_run        (w_run),
    .o_sample_en  (sample_en_o),
    .o_done       (w_done),
    .o_phase_q    (w_phase_q)
  );

  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      r_weights    <= {NUM_PAIRS{WEIGHT_RST}};
      r_ctr_cutoff <= '0;
      r_ctr_max    <= '0;
    end else begin
      if (w_wr_cut) r_ctr_cutoff <= wdata;
      if (w_wr_max) r_ctr_max    <= wdata;
      if (w_wr_wt) begin
        for (int k = 0; k < NUM_PAIRS; k++) begin
          if (w_wr_idx == 11'(k)) begin
            r_weights[k*NUM_WEIGHTS +: NUM_WEIGHTS] <= wdata[NUM_WEIGHTS-1:0];
          end
        end
      end
    end
  end

  always_comb begin
    w_rd_dat  = '0;
    w_rd_resp = RESP_SLVERR;
    if (araddr_q == START_ADDR) begin
      w_rd_dat  = {31'b0, w_run};
      w_rd_resp = RESP_OKAY;
    end else if (araddr_q == CTR_CUTOFF_ADDR) begin
      w_rd_dat  = r_ctr_cutoff;
      w_rd_resp = RESP_OKAY;
    end else if (araddr_q == CTR_MAX_ADDR) begin
      w_rd_dat  = r_ctr_max;
      w_rd_resp = RESP_OKAY;
    end else if (araddr_q == STATUS_ADDR) begin
      w_rd_dat  = {30'b0, w_done, w_run};
      w_rd_resp = RESP_OKAY;
    end else if (in_region(araddr_q, PHASE_ADDR_BASE) && (w_rd_idx < N_L)) begin
      w_rd_resp = RESP_OKAY;
      for (int i = 0; i < N; i++) begin
        if (w_rd_idx == 11'(i)) w_rd_dat = {31'b0, w_phase_q[i]};
      end
    end else if (in_region(araddr_q, WEIGHT_ADDR_BASE) && (w_rd_idx < NUM_PAIRS_L)) begin
      w_rd_resp = RESP_OKAY;
`ifdef ISING_RESP_WEIGHT_RDBACK_EN
      for (int k = 0; k < NUM_PAIRS; k++) begin
        if (w_rd_idx == 11'(k)) begin
          w_rd_dat = {{(32-NUM_WEIGHTS){1'b0}}, r_weights[k*NUM_WEIGHTS +: NUM_WEIGHTS]};
        end
      end
`else
      w_rd_dat = '0;
`endif
    end
  end

  // Read data registers off pre-edge state, so a same-edge write returns the old value.
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      r_rvalid <= 1'b0;
      r_rresp  <= RESP_OKAY;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= arvalid_q;
      if (arvalid_q) begin
        r_rdata <= w_rd_dat;
        r_rresp <= w_rd_resp;
      end
    end
  end

  assign rvalid    = r_rvalid;
  assign rresp     = r_rresp;
  assign rdata     = r_rdata;
  assign weights_o = r_weights;
  assign run_o     = w_run;

endmodule

// File: tb/tb_ising_csr_resp.sv
// Directed bench for ising_csr_resp: register table plus run / abort / restart / reset / ctr_max=0 sequences.
module tb_ising_csr_resp;

  localparam logic [31:0] A_START = 32'h0000_0000;
  localparam logic [31:0] A_CUT   = 32'h0000_0020;
  localparam logic [31:0] A_MAX   = 32'h0000_0040;
  localparam logic [31:0] A_STAT  = 32'h0000_0060;
  localparam logic [31:0] A_PH    = 32'h0001_0000;
  localparam logic [31:0] A_WT    = 32'h0002_0000;
  localparam logic [1:0]  OK      = 2'b00;
  localparam logic [1:0]  SLV     = 2'b10;
`ifdef ISING_RESP_WEIGHT_RDBACK_EN
  localparam logic [31:0] WT13_RD = 32'd4;
`else
  localparam logic [31:0] WT13_RD = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        axi_rstn;
  logic        wr_valid;
  logic [31:0] wr_addr;
  logic [31:0] wdata;
  logic        arvalid_q;
  logic [31:0] araddr_q;
  logic        rready;
  logic        rvalid;
  logic [1:0]  rresp;
  logic [31:0] rdata;
  logic [44:0] weights_o;
  logic        run_o;
  logic        sample_en_o;
  logic [5:0]  phase_i;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] dat;
    logic [31:0] exp_dat;
    logic [1:0]  exp_resp;
  } vec_t;
  vec_t vecs[16];

  ising_csr_resp dut (
    .clk         (clk),
    .axi_rstn    (axi_rstn),
    .wr_valid    (wr_valid),
    .wr_addr     (wr_addr),
    .wdata       (wdata),
    .arvalid_q   (arvalid_q),
    .araddr_q    (araddr_q),
    .rready      (rready),
    .rvalid      (rvalid),
    .rresp       (rresp),
    .rdata       (rdata),
    .weights_o   (weights_o),
    .run_o       (run_o),
    .sample_en_o (sample_en_o),
    .phase_i     (phase_i)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // All tasks are entered at a negedge and return at a negedge.
  task automatic do_wr(input logic [31:0] addr, input logic [31:0] dat);
    wr_valid = 1'b1;
    wr_addr  = addr;
    wdata    = dat;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [31:0] addr,
                          input logic [31:0] exp_d, input logic [1:0] exp_r);
    arvalid_q = 1'b1;
    araddr_q  = addr;
    @(negedge clk);
    arvalid_q = 1'b0;
    check({name, "_rvalid"}, 64'(rvalid), 64'd1);
    check({name, "_rdata"},  64'(rdata),  64'(exp_d));
    check({name, "_rresp"},  64'(rresp),  64'(exp_r));
  endtask

  logic [44:0] exp_w;
  logic [5:0]  exp_ph;

  initial begin
    axi_rstn  = 1'b0;
    wr_valid  = 1'b0;
    wr_addr   = '0;
    wdata     = '0;
    arvalid_q = 1'b0;
    araddr_q  = '0;
    rready    = 1'b1;
    phase_i   = '0;

    vecs[0]  = '{1'b0, A_STAT,          32'h0, 32'h0,   OK};
    vecs[1]  = '{1'b0, A_PH,            32'h0, 32'h0,   OK};
    vecs[2]  = '{1'b0, A_WT,            32'h0, 32'h0,   OK};
    vecs[3]  = '{1'b1, A_WT + 32*13,    32'h4, 32'h0,   OK};
    vecs[4]  = '{1'b1, A_WT + 32*3,     32'h1, 32'h0,   OK};
    vecs[5]  = '{1'b1, A_WT + 32*15,    32'h7, 32'h0,   OK};
    vecs[6]  = '{1'b0, A_WT + 32*15,    32'h0, 32'h0,   SLV};
    vecs[7]  = '{1'b0, A_WT + 32*13,    32'h0, WT13_RD, OK};
    vecs[8]  = '{1'b1, A_CUT,           32'h4, 32'h0,   OK};
    vecs[9]  = '{1'b1, A_MAX,           32'h8, 32'h0,   OK};
    vecs[10] = '{1'b0, A_CUT,           32'h0, 32'h4,   OK};
    vecs[11] = '{1'b0, A_MAX,           32'h0, 32'h8,   OK};
    vecs[12] = '{1'b0, 32'h0000_0080,   32'h0, 32'h0,   SLV};
    vecs[13] = '{1'b0, A_PH + 32*6,     32'h0, 32'h0,   SLV};
    vecs[14] = '{1'b0, 32'h0000_0024,   32'h0, 32'h0,   SLV};
    vecs[15] = '{1'b0, A_START,         32'h0, 32'h0,   OK};

    exp_w = '0;
    exp_w[41:39] = 3'b100;
    exp_w[11:9]  = 3'b001;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_rresp",  64'(rresp),  64'd0);
    check("rst_rdata",  64'(rdata),  64'd0);
    check("rst_run",    64'(run_o),  64'd0);
    check("rst_sample", 64'(sample_en_o), 64'd0);
    check("rst_weights", 64'(weights_o), 64'd0);
    axi_rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].is_wr) begin
        do_wr(vecs[i].addr, vecs[i].dat);
      end else begin
        rd_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_dat, vecs[i].exp_resp);
      end
    end
    check("weights_after_wr", 64'(weights_o), 64'(exp_w));

    // Full run: cutoff 4, max 8; phase_i only takes its final value in the counter-8 cycle
    phase_i = 6'b010010;
    do_wr(A_START, 32'h1);
    for (int c = 0; c <= 8; c++) begin
      check($sformatf("run_c%0d", c), 64'(run_o), 64'd1);
      check($sformatf("sample_c%0d", c), 64'(sample_en_o), 64'(c >= 4));
      if (c == 8) phase_i = 6'b101101;
      @(negedge clk);
    end
    phase_i = 6'b111111;
    check("run_after_latch", 64'(run_o), 64'd0);
    check("sample_after_latch", 64'(sample_en_o), 64'd0);
    rd_check("status_done", A_STAT, 32'd2, OK);
    exp_ph = 6'b101101;
    for (int i = 0; i < 6; i++) begin
      rd_check($sformatf("phase%0d", i), A_PH + 32'(32*i), {31'b0, exp_ph[i]}, OK);
    end

    // Same-edge read and write return the old value
    arvalid_q = 1'b1; araddr_q = A_CUT;
    wr_valid  = 1'b1; wr_addr  = A_CUT; wdata = 32'd9;
    @(negedge clk);
    arvalid_q = 1'b0; wr_valid = 1'b0;
    check("rw_same_edge_old", 64'(rdata), 64'd4);
    rd_check("cut_new", A_CUT, 32'd9, OK);

    // Abort at counter 3; writes during RUN dropped
    do_wr(A_START, 32'h1);
    check("abort_run_c0", 64'(run_o), 64'd1);
    do_wr(A_WT, 32'h7);
    do_wr(A_MAX, 32'd100);
    @(negedge clk);
    check("abort_run_c3", 64'(run_o), 64'd1);
    do_wr(A_START, 32'h0);
    check("abort_run_low", 64'(run_o), 64'd0);
    rd_check("abort_status", A_STAT, 32'd0, OK);
    rd_check("abort_max_kept", A_MAX, 32'd8, OK);
    check("abort_weights_kept", 64'(weights_o), 64'(exp_w));
    for (int i = 0; i < 6; i++) begin
      rd_check($sformatf("abort_phase%0d", i), A_PH + 32'(32*i), {31'b0, exp_ph[i]}, OK);
    end

    // START coincident with final counter match: restart wins, no latch
    do_wr(A_START, 32'h1);
    for (int c = 0; c < 8; c++) @(negedge clk);
    do_wr(A_START, 32'h1);
    check("restart_run_high", 64'(run_o), 64'd1);
    do_wr(A_START, 32'h0);
    check("restart_abort_low", 64'(run_o), 64'd0);
    rd_check("restart_phase1", A_PH + 32, 32'd0, OK);

    // Async reset at counter 5
    do_wr(A_CUT, 32'd2);
    do_wr(A_START, 32'h1);
    for (int c = 0; c < 5; c++) @(negedge clk);
    check("pre_rst_sample", 64'(sample_en_o), 64'd1);
    axi_rstn = 1'b0;
    #1;
    check("async_rst_run", 64'(run_o), 64'd0);
    check("async_rst_sample", 64'(sample_en_o), 64'd0);
    check("async_rst_rvalid", 64'(rvalid), 64'd0);
    @(negedge clk);
    axi_rstn = 1'b1;
    @(negedge clk);
    check("post_rst_weights", 64'(weights_o), 64'd0);
    rd_check("post_rst_cut", A_CUT, 32'd0, OK);
    rd_check("post_rst_max", A_MAX, 32'd0, OK);
    rd_check("post_rst_status", A_STAT, 32'd0, OK);
    rd_check("post_rst_phase0", A_PH, 32'd0, OK);
    rd_check("post_rst_wt13", A_WT + 32*13, 32'd0, OK);

    // ctr_max = 0: one RUN cycle, latch at t+1
    phase_i = 6'b100001;
    do_wr(A_START, 32'h1);
    check("max0_run", 64'(run_o), 64'd1);
    check("max0_sample", 64'(sample_en_o), 64'd1);
    @(negedge clk);
    phase_i = 6'b011110;
    check("max0_run_low", 64'(run_o), 64'd0);
    rd_check("max0_status", A_STAT, 32'd2, OK);
    rd_check("max0_phase0", A_PH, 32'd1, OK);
    rd_check("max0_phase1", A_PH + 32, 32'd0, OK);
    rd_check("max0_phase5", A_PH + 32*5, 32'd1, OK);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ising_csr_resp.md
# ising_csr_resp

Register-file responder for the Ising array. It decodes the simple write/read bus that a host or bench drives: counter cutoff and max, upper-triangular coupling weights, start, status and phase readback. It also runs the anneal-window state machine that tells the core when to run and when to sample. It sits between the bus wrapper and the coupled-oscillator core and owns every programmable state bit of the solver.

## Interface
- N, 6: number of spins; the number of pairs is NUM_PAIRS = N*(N-1)/2
- NUM_WEIGHTS, 3: bits per coupling weight
- WEIGHT_RST, 0: reset and clear value of every weight
---
- clk  in  1  single clock
- axi_rstn  in  1  asynchronous active-low reset
- wr_valid  in  1  write strobe, sampled at posedge
- wr_addr  in  32  write address
- wdata  in  32  write data
- arvalid_q  in  1  read request, sampled at posedge
- araddr_q  in  32  read address
- rready  in  1  reserved, ignored; no read backpressure
- rvalid  out  1  read data valid
- rresp  out  2  00 OKAY, 10 SLVERR
- rdata  out  32  read data
- weights_o  out  NUM_PAIRS*NUM_WEIGHTS  flat weight bus; pair k occupies [k*NUM_WEIGHTS +: NUM_WEIGHTS]
- run_o  out  1  core enable, high in RUN
- sample_en_o  out  1  high in RUN while counter >= ctr_cutoff
- phase_i  in  N  live spin phases from the core

## Operation
- Address map, with a 32-byte stride between entries:
  - START_ADDR 0x0000_0000
  - CTR_CUTOFF_ADDR 0x0000_0020
  - CTR_MAX_ADDR 0x0000_0040
  - STATUS_ADDR 0x0000_0060
  - PHASE_ADDR_BASE 0x0001_0000 + 32*i, for i < N
  - WEIGHT_ADDR_BASE 0x0002_0000 + 32*k, for k < NUM_PAIRS
- Pair index k runs row-major over i<j: (0,1), (0,2), …, (0,N-1), (1,2), …, (N-2,N-1).
- Weight write: wdata[NUM_WEIGHTS-1:0] is stored. Writes with k >= NUM_PAIRS, or to any unmapped address, are dropped.
- CTR_CUTOFF and CTR_MAX are full 32-bit registers.
- Writes to the weight, CTR_CUTOFF and CTR_MAX registers are dropped while in RUN. START is always accepted.
- The run FSM, held in ising_run_ctrl, has three states:
  - IDLE: on START with wdata[0]=1, go to RUN and set counter to 0.
  - RUN: counter increments every cycle. When counter == ctr_max, latch phase_i into phase_q and go to DONE. START with wdata[0]=0 aborts to IDLE with phase_q unchanged.
  - DONE: on START with wdata[0]=1, go to RUN (a restart); phase_q holds until the next latch.
- If ctr_max == 0, the latch happens in the first RUN cycle.
- If ctr_cutoff > ctr_max, sample_en_o never asserts.
- The counter is 32-bit. It cannot wrap, because the run terminates at ctr_max.
- Read data:
  - STATUS returns {30'b0, done, running}.
  - PHASE i returns {31'b0, phase_q[i]}.
  - START returns {31'b0, running}.
  - CTR registers return their value.
  - Unmapped addresses, and weight index >= NUM_PAIRS, return rdata 0 with rresp 10.
- Reset values:
  - rvalid 0, rresp 00, rdata 0
  - run_o 0, sample_en_o 0
  - weights WEIGHT_RST
  - counters 0, phase_q 0
  - state IDLE
- Reset asserted mid-run forces IDLE asynchronously and clears all of the above.

## Timing
- A write takes effect at the posedge where wr_valid is high; the new value is visible on outputs immediately after that edge.
- A START write at edge t:
  - run_o is high after t.
  - Counter value 0 is presented in cycle t+1.
  - The latch occurs at edge t+1+ctr_max.
  - run_o falls after that same edge.
- Read latency is 1 cycle. rdata/rresp are registered from araddr_q at the edge where arvalid_q is high, with rvalid=1 after that edge. rvalid=0 after any edge with arvalid_q low.
- Back-to-back reads are supported, one per cycle.
- A read and a write to the same address at the same edge return the old value.
- START and the final counter match at the same edge: START wins (restart or abort), and no latch occurs.

## Configuration
- ISING_RESP_WEIGHT_RDBACK_EN
  - Defined: weight addresses read back the stored weight, zero-extended, with rresp 00.
  - Undefined: weight reads return 0 with rresp 00, and the per-weight read mux is not built.

## Structure
- Package ising_csr_pkg holds:
  - the address constants above and the 32-byte stride
  - the rresp encodings
  - the run-state enum {IDLE, RUN, DONE}
- Sub-module ising_run_ctrl holds the FSM, the 32-bit counter, the cutoff compare and the phase_q latch.
- The top level holds address decode, the weight registers and the read mux.

## Test plan
- Reset, then read STATUS, PHASE 0 and WEIGHT 0 → rdata 0, rresp 00, weights_o all WEIGHT_RST.
- N=6: write weight k=13 (DF) = 0x4 and k=3 (AE) = 0x1 → weights_o[41:39]=100 and [11:9]=001. A write to k=15 is dropped; reading k=15 gives rresp 10.
- Program CTR_CUTOFF=4 and CTR_MAX=8, then START=1 at edge t with phase_i=6'b101101:
  - sample_en_o is high over counter values 4..8.
  - phase_q is latched at edge t+9.
  - STATUS reads 2.
  - Reading PHASE 0..5 gives 1,0,1,1,0,1.
- Weight write during RUN is ignored. START=0 at counter 3 → IDLE, run_o low next cycle, phase_q unchanged.
- Deassert axi_rstn at counter 5 → run_o and sample_en_o drop immediately. After release, all registers are at reset values.
- ctr_max=0 → run_o high for exactly 1 cycle, and the latch happens at edge t+1.
